// File: rtl/qu_common_pkg.sv
// Shared back-end types and sizes.
// Perf counters in wb_arbiter are enabled by QU_WB_PERF_CNT_EN.
package qu_common;

    localparam int PHY_RF_ADDR_WIDTH = 6;
    localparam int QU_DATA_WIDTH     = 32;
    localparam int QU_NUM_FU         = 4;

    typedef struct packed {
        logic [PHY_RF_ADDR_WIDTH-1:0] rd_addr;
        logic [QU_DATA_WIDTH-1:0]     data;
    } wb_req_t;

    function automatic logic [31:0] sat_inc32(input logic [31:0] v);
        return (v == '1) ? v : v + 32'd1;
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: first requester at or after rr_ptr wins.
// Pointer moves past the winner only when advance is high.
module rr_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int IDX_W   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [NUM_REQ-1:0] req,
    input  logic               advance,
    output logic [NUM_REQ-1:0] grant,
    output logic [IDX_W-1:0]   grant_idx
);

    logic [IDX_W-1:0] rr_ptr;
    logic             found;

    always_comb begin : scan
        int j;
        j         = 0;
        found     = 1'b0;
        grant     = '0;
        grant_idx = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            j = int'(rr_ptr) + k;
            if (j >= NUM_REQ) j = j - NUM_REQ;
            if (!found && req[j]) begin
                found     = 1'b1;
                grant[j]  = 1'b1;
                grant_idx = IDX_W'(j);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rr_ptr <= '0;
        end else if (advance && found) begin
            if (grant_idx == IDX_W'(NUM_REQ - 1))
                rr_ptr <= '0;
            else
                rr_ptr <= grant_idx + IDX_W'(1);
        end
    end

endmodule

// File: rtl/wb_arbiter.sv
// Writeback arbiter: round-robin over FU results into one RF/busy-table write.
// Optional counters wb_conflict_cnt/wb_stall_cnt under QU_WB_PERF_CNT_EN.
module wb_arbiter
    import qu_common::*;
#(
    parameter int NUM_FU        = QU_NUM_FU,
    parameter int RF_ADDR_WIDTH = PHY_RF_ADDR_WIDTH,
    parameter int DATA_WIDTH    = 32
) (
    input  logic                                    clk,
    input  logic                                    rst,
    input  logic [NUM_FU-1:0]                       fu_valid,
    output logic [NUM_FU-1:0]                       fu_ready,
    input  logic [NUM_FU-1:0][RF_ADDR_WIDTH-1:0]    fu_rd_addr,
    input  logic [NUM_FU-1:0][DATA_WIDTH-1:0]       fu_data,
    input  logic                                    wb_stall,
    output logic                                    rf_wr_en,
    output logic [RF_ADDR_WIDTH-1:0]                rf_rd_addr,
    output logic [DATA_WIDTH-1:0]                   rf_data_out,
    output logic                                    busy_table_wr_en,
    output logic [RF_ADDR_WIDTH-1:0]                busy_table_wr_addr,
    output logic                                    busy_table_wr_data
`ifdef QU_WB_PERF_CNT_EN
    ,
    output logic [31:0]                             wb_conflict_cnt,
    output logic [31:0]                             wb_stall_cnt
`endif
);

    localparam int IDX_W = (NUM_FU > 1) ? $clog2(NUM_FU) : 1;

    logic [NUM_FU-1:0]        grant;
    logic [IDX_W-1:0]         grant_idx;
    logic                     accept;
    logic                     wr_ok;
    logic                     out_valid;
    logic [RF_ADDR_WIDTH-1:0] out_addr;
    logic [DATA_WIDTH-1:0]    out_data;

    rr_arbiter #(
        .NUM_REQ (NUM_FU),
        .IDX_W   (IDX_W)
    ) u_rr (
        .clk       (clk),
        .rst       (rst),
        .req       (fu_valid),
        .advance   (~wb_stall),
        .grant     (grant),
        .grant_idx (grant_idx)
    );

    assign fu_ready = grant & {NUM_FU{~wb_stall}};
    assign accept   = |fu_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid <= 1'b0;
            out_addr  <= '0;
            out_data  <= '0;
        end else if (!wb_stall) begin
            out_valid <= accept;
            if (accept) begin
                out_addr <= fu_rd_addr[grant_idx];
                out_data <= fu_data[grant_idx];
            end
        end
    end

    // p0 is hardwired zero: the entry drains but never writes
    assign wr_ok = out_valid & ~wb_stall & ~rst & (out_addr != '0);

    assign rf_wr_en           = wr_ok;
    assign rf_rd_addr         = out_addr;
    assign rf_data_out        = out_data;
    assign busy_table_wr_en   = wr_ok;
    assign busy_table_wr_addr = out_addr;
    assign busy_table_wr_data = 1'b0;

`ifdef QU_WB_PERF_CNT_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            wb_conflict_cnt <= '0;
            wb_stall_cnt    <= '0;
        end else begin
            if (!wb_stall && ($countones(fu_valid) >= 2))
                wb_conflict_cnt <= sat_inc32(wb_conflict_cnt);
            if (wb_stall && out_valid)
                wb_stall_cnt <= sat_inc32(wb_stall_cnt);
        end
    end
`endif

endmodule

// File: tb/tb_wb_arbiter.sv
// Directed bench for wb_arbiter with an arbitration model and write scoreboard.
// Counter checks are compiled in when QU_WB_PERF_CNT_EN is defined.
module tb_wb_arbiter;
    import qu_common::*;

    localparam int N  = QU_NUM_FU;
    localparam int AW = PHY_RF_ADDR_WIDTH;
    localparam int DW = QU_DATA_WIDTH;

    logic                  clk = 1'b0;
    logic                  rst;
    logic [N-1:0]          fu_valid;
    logic [N-1:0]          fu_ready;
    logic [N-1:0][AW-1:0]  fu_rd_addr;
    logic [N-1:0][DW-1:0]  fu_data;
    logic                  wb_stall;
    logic                  rf_wr_en;
    logic [AW-1:0]         rf_rd_addr;
    logic [DW-1:0]         rf_data_out;
    logic                  busy_table_wr_en;
    logic [AW-1:0]         busy_table_wr_addr;
    logic                  busy_table_wr_data;
`ifdef QU_WB_PERF_CNT_EN
    logic [31:0]           wb_conflict_cnt;
    logic [31:0]           wb_stall_cnt;
`endif

    always #5 clk = ~clk;

    wb_arbiter #(
        .NUM_FU        (N),
        .RF_ADDR_WIDTH (AW),
        .DATA_WIDTH    (DW)
    ) dut (
        .clk                (clk),
        .rst                (rst),
        .fu_valid           (fu_valid),
        .fu_ready           (fu_ready),
        .fu_rd_addr         (fu_rd_addr),
        .fu_data            (fu_data),
        .wb_stall           (wb_stall),
        .rf_wr_en           (rf_wr_en),
        .rf_rd_addr         (rf_rd_addr),
        .rf_data_out        (rf_data_out),
        .busy_table_wr_en   (busy_table_wr_en),
        .busy_table_wr_addr (busy_table_wr_addr),
        .busy_table_wr_data (busy_table_wr_data)
`ifdef QU_WB_PERF_CNT_EN
        ,
        .wb_conflict_cnt    (wb_conflict_cnt),
        .wb_stall_cnt       (wb_stall_cnt)
`endif
    );

    int      checks = 0;
    int      errors = 0;
    wb_req_t sb_q[$];

    int           m_ptr   = 0;
    logic         m_valid = 1'b0;
    wb_req_t      m_out   = '0;
    int           m_gidx  = -1;
    logic [N-1:0] m_grant = '0;
    logic [31:0]  m_conf  = '0;
    logic [31:0]  m_stl   = '0;
    int           wr_cnt[N];

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic int pick(input logic [N-1:0] v, input int p);
        for (int k = 0; k < N; k++) begin
            if (v[(p + k) % N]) return (p + k) % N;
        end
        return -1;
    endfunction

    task automatic sample();
        logic    exp_wr;
        wb_req_t e;
        @(negedge clk);
        m_gidx  = pick(fu_valid, m_ptr);
        m_grant = '0;
        if (m_gidx >= 0 && !wb_stall) m_grant[m_gidx] = 1'b1;
        check("fu_ready", 32'(fu_ready), 32'(m_grant));
        exp_wr = m_valid && !wb_stall && !rst && (m_out.rd_addr != '0);
        check("rf_wr_en", 32'(rf_wr_en), 32'(exp_wr));
        check("bt_wr_en", 32'(busy_table_wr_en), 32'(exp_wr));
        check("bt_wr_data", 32'(busy_table_wr_data), 32'd0);
        if (exp_wr) begin
            check("sb_pending", 32'(sb_q.size() != 0), 32'd1);
            if (sb_q.size() != 0) begin
                e = sb_q.pop_front();
                check("rf_addr", 32'(rf_rd_addr), 32'(e.rd_addr));
                check("bt_addr", 32'(busy_table_wr_addr), 32'(e.rd_addr));
                check("rf_data", rf_data_out, e.data);
            end
        end
`ifdef QU_WB_PERF_CNT_EN
        check("conflict_cnt", wb_conflict_cnt, m_conf);
        check("stall_cnt", wb_stall_cnt, m_stl);
`endif
    endtask

    task automatic adv();
        if (rst) begin
            m_ptr   = 0;
            m_valid = 1'b0;
            m_out   = '0;
            m_conf  = '0;
            m_stl   = '0;
            sb_q.delete();
        end else begin
            if (!wb_stall && ($countones(fu_valid) >= 2) && m_conf != '1)
                m_conf = m_conf + 1;
            if (wb_stall && m_valid && m_stl != '1)
                m_stl = m_stl + 1;
            if (!wb_stall) begin
                if (m_gidx >= 0) begin
                    m_valid       = 1'b1;
                    m_out.rd_addr = fu_rd_addr[m_gidx];
                    m_out.data    = fu_data[m_gidx];
                    if (m_out.rd_addr != '0) sb_q.push_back(m_out);
                    m_ptr = (m_gidx + 1) % N;
                end else begin
                    m_valid = 1'b0;
                end
            end
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst        = 1'b1;
        wb_stall   = 1'b0;
        fu_valid   = '0;
        fu_rd_addr = '0;
        fu_data    = '0;
        for (int i = 0; i < N; i++) wr_cnt[i] = 0;
        sample(); adv();
        sample(); adv();
        rst = 1'b0;

        // reset state
        sample();
        check("rst_wr_en", 32'(rf_wr_en), 32'd0);
        check("rst_addr", 32'(rf_rd_addr), 32'd0);
        check("rst_data", rf_data_out, 32'd0);
        check("rst_bt_addr", 32'(busy_table_wr_addr), 32'd0);
        adv();

        // single request from FU0
        fu_valid      = 4'b0001;
        fu_rd_addr[0] = AW'(5);
        fu_data[0]    = 32'hDEADBEEF;
        sample();
        check("single_ready", 32'(fu_ready), 32'h1);
        adv();
        fu_valid = '0;
        sample();
        check("single_wr_en", 32'(rf_wr_en), 32'd1);
        check("single_addr", 32'(rf_rd_addr), 32'd5);
        check("single_data", rf_data_out, 32'hDEADBEEF);
        check("single_bt_en", 32'(busy_table_wr_en), 32'd1);
        adv();

        // register zero from FU2
        fu_valid      = 4'b0100;
        fu_rd_addr[2] = '0;
        fu_data[2]    = 32'h1234;
        sample();
        check("p0_ready", 32'(fu_ready[2]), 32'd1);
        adv();
        fu_valid = '0;
        sample();
        check("p0_wr_en", 32'(rf_wr_en), 32'd0);
        check("p0_bt_en", 32'(busy_table_wr_en), 32'd0);
        adv();

        // stall hold on pending {7, 0x11}
        fu_valid      = 4'b0010;
        fu_rd_addr[1] = AW'(7);
        fu_data[1]    = 32'h11;
        sample(); adv();
        wb_stall      = 1'b1;
        fu_valid      = 4'b0001;
        fu_rd_addr[0] = AW'(3);
        fu_data[0]    = 32'h33;
        for (int c = 0; c < 3; c++) begin
            sample();
            check("stall_wr_en", 32'(rf_wr_en), 32'd0);
            check("stall_ready", 32'(fu_ready), 32'd0);
            adv();
        end
        wb_stall = 1'b0;
        sample();
        check("unstall_wr_en", 32'(rf_wr_en), 32'd1);
        check("unstall_addr", 32'(rf_rd_addr), 32'd7);
        check("unstall_data", rf_data_out, 32'h11);
        adv();
        fu_valid = '0;
        sample();
        check("once_addr", 32'(rf_rd_addr), 32'd3);
        adv();
        sample(); adv();

        // reset with {9} pending
        fu_valid      = 4'b1000;
        fu_rd_addr[3] = AW'(9);
        fu_data[3]    = 32'h99;
        sample(); adv();
        fu_valid = '0;
        rst      = 1'b1;
        sample();
        check("rstmid_wr_en", 32'(rf_wr_en), 32'd0);
        adv();
        rst = 1'b0;
        sample();
        check("rstmid_after", 32'(rf_wr_en), 32'd0);
        adv();

        // round robin, all FUs valid for 8 cycles
        for (int i = 0; i < N; i++) begin
            fu_rd_addr[i] = AW'(10 + i);
            fu_data[i]    = 32'hA0 + 32'(i);
        end
        fu_valid = '1;
        for (int c = 0; c < 8; c++) begin
            sample();
            check("rr_grant", 32'(fu_ready), 32'd1 << (c % N));
            if (rf_wr_en && rf_rd_addr >= AW'(10) && rf_rd_addr < AW'(10 + N))
                wr_cnt[int'(rf_rd_addr) - 10]++;
            adv();
        end
        fu_valid = '0;
        sample();
        if (rf_wr_en && rf_rd_addr >= AW'(10) && rf_rd_addr < AW'(10 + N))
            wr_cnt[int'(rf_rd_addr) - 10]++;
        adv();
        for (int i = 0; i < N; i++) check("rr_writes", 32'(wr_cnt[i]), 32'd2);
        fu_valid = '1;
        sample();
        check("rr_wrap", 32'(fu_ready), 32'h1);
        adv();
        fu_valid = '0;
        sample(); adv();

        // conflict counting
        rst = 1'b1;
        sample(); adv();
        rst = 1'b0;
        fu_valid      = 4'b0011;
        fu_rd_addr[0] = AW'(1);
        fu_rd_addr[1] = AW'(2);
        for (int c = 0; c < 4; c++) begin
            sample(); adv();
        end
        fu_valid = '0;
        sample();
`ifdef QU_WB_PERF_CNT_EN
        check("conflict_4", wb_conflict_cnt, 32'd4);
`endif
        adv();
        sample(); adv();

        check("sb_drained", 32'(sb_q.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/wb_arbiter.md
Name: wb_arbiter

Overview:
- Writeback arbiter at the tail of the back end. It collects completed results from NUM_FU execution units and drives the single physical-RF write port (rf_wr_en / rf_rd_addr / rf_data_in on the core).
- In the same cycle it clears the destination's busy bit through the front end's busy-table write port (busy_table_wr_en / _addr / _data), which is currently tied off.
- Round-robin arbitration, one registered output stage, one write per cycle.

Parameters:
- NUM_FU, 4, number of execution-unit result sources (2..8).
- RF_ADDR_WIDTH, PHY_RF_ADDR_WIDTH, physical register address width.
- DATA_WIDTH, 32, result data width.

Ports:
- clk  in  1  clock.
- rst  in  1  reset; synchronous, active-high.
- fu_valid  in  NUM_FU  result valid, one bit per FU.
- fu_ready  out  NUM_FU  result accepted this cycle, one bit per FU.
- fu_rd_addr  in  NUM_FU x RF_ADDR_WIDTH  destination physical register, per FU.
- fu_data  in  NUM_FU x DATA_WIDTH  result value, per FU.
- wb_stall  in  1  downstream hold; freezes the output stage.
- rf_wr_en  out  1  physical RF write enable.
- rf_rd_addr  out  RF_ADDR_WIDTH  physical RF write address.
- rf_data_out  out  DATA_WIDTH  physical RF write data.
- busy_table_wr_en  out  1  busy-table write enable.
- busy_table_wr_addr  out  RF_ADDR_WIDTH  busy-table write address.
- busy_table_wr_data  out  1  busy-table write data; always 0 (not busy).

Behaviour:
- Handshake:
  - A transfer from FU i occurs when fu_valid[i] & fu_ready[i] are both high at a rising edge.
  - An FU holds fu_valid, fu_rd_addr and fu_data stable until it is accepted.
  - fu_ready is combinational from fu_valid, rr_ptr and wb_stall. fu_ready[i] = grant[i] & ~wb_stall, and at most one bit is high.
- Arbitration:
  - grant goes to the first valid FU scanning rr_ptr, rr_ptr+1, … modulo NUM_FU.
  - On an accepted transfer from FU g: rr_ptr <= (g+1) mod NUM_FU. Wrap-around: g = NUM_FU-1 gives rr_ptr = 0.
  - With no valid input, rr_ptr is unchanged.
- Output stage:
  - Registers out_valid, out_addr and out_data.
  - On an accept: out_valid <= 1 and the address/data are captured.
  - With wb_stall=0 and no accept: out_valid <= 0.
  - With wb_stall=1: all output registers hold and there are no accepts.
- Output drive:
  - rf_wr_en = busy_table_wr_en = out_valid & ~wb_stall & (out_addr != 0).
  - rf_rd_addr = busy_table_wr_addr = out_addr; rf_data_out = out_data.
- Latency:
  - A result accepted at edge N is written to the RF and busy table during cycle N+1 (written at edge N+1).
  - Sustained throughput is 1 result per cycle.
- Physical register 0:
  - A result for address 0 is accepted and occupies the output stage.
  - rf_wr_en and busy_table_wr_en stay 0 for it; the write is dropped.
- Stall on a pending entry: the entry is held and written in the first cycle with wb_stall=0.
- Reset values:
  - out_valid=0, out_addr=0, out_data=0, rr_ptr=0.
  - All write enables are 0; busy_table_wr_data is always 0.
- Reset while an entry is pending: the entry is discarded and no write occurs.

Optional Feature:
- Macro: QU_WB_PERF_CNT_EN.
- Defined:
  - Adds output wb_conflict_cnt (32 bits). It increments on every non-stalled cycle in which ≥2 fu_valid bits are high.
  - Adds output wb_stall_cnt (32 bits). It increments on every cycle with wb_stall=1 and out_valid=1.
  - Both counters saturate at all-ones and reset to 0.
- Undefined: neither port nor counter exists.

Decomposition:
- Package qu_common:
  - typedef wb_req_t {rd_addr, data}.
  - constant QU_NUM_FU.
  - Reuse PHY_RF_ADDR_WIDTH.
- Sub-module rr_arbiter (NUM_REQ parameter):
  - Inputs: req and advance enable.
  - Outputs: one-hot grant and encoded grant index; holds rr_ptr internally.
  - Reusable by the back-end issue select.

Test Plan:
- Single request: after reset, fu_valid=0001, FU0 {addr=5, data=0xDEADBEEF} → fu_ready=0001 at edge N. At cycle N+1: rf_wr_en=1, rf_rd_addr=5, rf_data_out=0xDEADBEEF, busy_table_wr_en=1, busy_table_wr_data=0.
- Round-robin fairness: all four FUs held valid for 8 cycles → grant order 0,1,2,3,0,1,2,3; each FU is written twice; rr_ptr returns to 0.
- Stall hold: entry {addr=7, data=0x11} pending, wb_stall=1 for 3 cycles → rf_wr_en=0 and fu_ready=0000 for those cycles. On the first cycle with wb_stall=0: rf_wr_en=1, addr=7, data=0x11, written exactly once.
- Register zero: FU2 {addr=0, data=0x1234} → fu_ready[2]=1, but rf_wr_en=0 and busy_table_wr_en=0 on the next cycle.
- Reset mid-operation: rst asserted the cycle after accepting {addr=9} → no write to 9 occurs; out_valid=0 and rr_ptr=0 after reset.
- With QU_WB_PERF_CNT_EN: FU0 and FU1 valid together for 4 non-stalled cycles → wb_conflict_cnt=4.
